// File: rtl/ps2_scan_parser.sv
// Folds PS/2 scan-code set 2 byte sequences (E0 / F0 / E1 prefixes) into single
// press/release events, tracks the currently held key and drops typematic repeats.
module ps2_scan_parser #(
    parameter int TIMEOUT_CYCLES  = 2500000,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] din,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       extended,
    output logic       released,
    output logic [7:0] held_code,
    output logic       held_ext,
    output logic       seq_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] B_EXT   = 8'hE0;
    localparam logic [7:0] B_BRK   = 8'hF0;
    localparam logic [7:0] B_PAUSE = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_to_cnt;
    logic [2:0]       r_skip;

    logic       r_key_valid;
    logic [7:0] r_key_code;
    logic       r_extended;
    logic       r_released;
    logic [7:0] r_held_code;
    logic       r_held_ext;
    logic       r_seq_err;

    logic w_fake_shift;
    logic w_idle_drop;
    logic w_make;
    logic w_brk;
    logic w_ev_ext;
    logic w_pause_ev;
    logic w_match;
    logic w_repeat;

    assign w_fake_shift = (din == 8'h12) || (din == 8'h59);

    // Controller responses (BAT ok, ACK, echo, resend) and error bytes carry no key.
    assign w_idle_drop = (din == 8'hAA) || (din == 8'hFA) || (din == 8'hEE) ||
                         (din == 8'hFE) || (din == 8'h00) || (din == 8'hFF);

    always_comb begin
        w_make     = 1'b0;
        w_brk      = 1'b0;
        w_ev_ext   = 1'b0;
        w_pause_ev = 1'b0;
        if (rx_done_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (din != B_EXT && din != B_BRK && din != B_PAUSE && !w_idle_drop)
                        w_make = 1'b1;
                end
                S_EXT: begin
                    if (din != B_BRK && !w_fake_shift) begin
                        w_make   = 1'b1;
                        w_ev_ext = 1'b1;
                    end
                end
                S_BRK: begin
                    w_brk = 1'b1;
                end
                S_EXT_BRK: begin
                    if (!w_fake_shift) begin
                        w_brk    = 1'b1;
                        w_ev_ext = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (r_skip == 3'd1)
                        w_pause_ev = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_match  = (din == r_held_code) && (w_ev_ext == r_held_ext);
    assign w_repeat = SUPPRESS_REPEAT && w_make && w_match;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_to_cnt    <= '0;
            r_skip      <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= 8'h00;
            r_extended  <= 1'b0;
            r_released  <= 1'b0;
            r_held_code <= 8'h00;
            r_held_ext  <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            r_seq_err   <= 1'b0;

            if (rx_done_tick) begin
                r_to_cnt <= '0;
                case (r_state)
                    S_IDLE: begin
                        if (din == B_EXT) begin
                            r_state <= S_EXT;
                        end else if (din == B_BRK) begin
                            r_state <= S_BRK;
                        end else if (din == B_PAUSE) begin
                            r_state <= S_PAUSE;
                            r_skip  <= PAUSE_SKIP;
                        end
                    end
                    S_EXT: begin
                        r_state <= (din == B_BRK) ? S_EXT_BRK : S_IDLE;
                    end
                    S_BRK, S_EXT_BRK: begin
                        r_state <= S_IDLE;
                    end
                    S_PAUSE: begin
                        if (r_skip == 3'd1) begin
                            r_state <= S_IDLE;
                            r_skip  <= '0;
                        end else begin
                            r_skip <= r_skip - 3'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (r_state != S_IDLE) begin
                // A byte arriving on the expiry cycle takes the branch above instead.
                if (r_to_cnt == TO_LAST) begin
                    r_state   <= S_IDLE;
                    r_to_cnt  <= '0;
                    r_skip    <= '0;
                    r_seq_err <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + CNT_W'(1);
                end
            end

            if (w_make && !w_repeat) begin
                r_key_valid <= 1'b1;
                r_key_code  <= din;
                r_extended  <= w_ev_ext;
                r_released  <= 1'b0;
                r_held_code <= din;
                r_held_ext  <= w_ev_ext;
            end

            if (w_brk) begin
                r_key_valid <= 1'b1;
                r_key_code  <= din;
                r_extended  <= w_ev_ext;
                r_released  <= 1'b1;
                if (w_match) begin
                    r_held_code <= 8'h00;
                    r_held_ext  <= 1'b0;
                end
            end

            // Pause has no break code, so it never becomes the held key.
            if (w_pause_ev) begin
                r_key_valid <= 1'b1;
                r_key_code  <= B_PAUSE;
                r_extended  <= 1'b0;
                r_released  <= 1'b0;
            end
        end
    end

    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign extended  = r_extended;
    assign released  = r_released;
    assign held_code = r_held_code;
    assign held_ext  = r_held_ext;
    assign seq_err   = r_seq_err;

endmodule

// File: tb/tb_ps2_scan_parser.sv
// Scoreboard bench for ps2_scan_parser: expected events are queued as byte
// sequences are driven and popped when key_valid fires.
module tb_ps2_scan_parser;

    localparam int TO = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] din = 8'h00;

    logic       key_valid, extended, released, held_ext, seq_err;
    logic [7:0] key_code, held_code;

    logic       nr_key_valid, nr_extended, nr_released, nr_held_ext, nr_seq_err;
    logic [7:0] nr_key_code, nr_held_code;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       rel;
        logic [7:0] hc;
        logic       he;
    } ev_t;

    ev_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int seq_cnt = 0;
    int nr_cnt  = 0;
    logic tick_d = 1'b0;

    ps2_scan_parser #(.TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b1)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .din(din),
        .key_valid(key_valid), .key_code(key_code), .extended(extended),
        .released(released), .held_code(held_code), .held_ext(held_ext),
        .seq_err(seq_err)
    );

    ps2_scan_parser #(.TIMEOUT_CYCLES(TO), .SUPPRESS_REPEAT(1'b0)) dut_nr (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .din(din),
        .key_valid(nr_key_valid), .key_code(nr_key_code), .extended(nr_extended),
        .released(nr_released), .held_code(nr_held_code), .held_ext(nr_held_ext),
        .seq_err(nr_seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] code, input logic ext, input logic rel,
                        input logic [7:0] hc, input logic he);
        ev_t e;
        e.code = code; e.ext = ext; e.rel = rel; e.hc = hc; e.he = he;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_done_tick = 1'b1;
        din = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    task automatic send_burst(input logic [7:0] b, input int n);
        @(negedge clk);
        rx_done_tick = 1'b1;
        din = b;
        repeat (n) @(negedge clk);
        rx_done_tick = 1'b0;
    endtask

    always @(posedge clk) tick_d <= rx_done_tick;

    // Scoreboard side: every key_valid must match the oldest queued event.
    always @(negedge clk) begin
        if (!reset) begin
            if (key_valid) begin
                if (exp_q.size() == 0) begin
                    check("kv_unexpected", 32'd1, 32'd0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("kv_latency", 32'(tick_d), 32'd1);
                    check("key_code", 32'(key_code), 32'(e.code));
                    check("extended", 32'(extended), 32'(e.ext));
                    check("released", 32'(released), 32'(e.rel));
                    check("held_code", 32'(held_code), 32'(e.hc));
                    check("held_ext", 32'(held_ext), 32'(e.he));
                end
            end
            if (seq_err) seq_cnt++;
            if (nr_key_valid) nr_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int nr_base;

        repeat (3) @(negedge clk);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_key_code", 32'(key_code), 32'd0);
        check("rst_extended", 32'(extended), 32'd0);
        check("rst_released", 32'(released), 32'd0);
        check("rst_held_code", 32'(held_code), 32'd0);
        check("rst_held_ext", 32'(held_ext), 32'd0);
        check("rst_seq_err", 32'(seq_err), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Plain make then break.
        push(8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0);
        send(8'h1C);
        push(8'h1C, 1'b0, 1'b1, 8'h00, 1'b0);
        send(8'hF0); send(8'h1C);

        // Extended make and break.
        push(8'h75, 1'b1, 1'b0, 8'h75, 1'b1);
        send(8'hE0); send(8'h75);
        push(8'h75, 1'b1, 1'b1, 8'h00, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h75);

        // Typematic repeats on back-to-back ticks.
        @(negedge clk);
        nr_base = nr_cnt;
        push(8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0);
        send_burst(8'h1C, 3);
        @(negedge clk);
        check("nr_repeat_count", 32'(nr_cnt - nr_base), 32'd3);
        push(8'h1C, 1'b0, 1'b1, 8'h00, 1'b0);
        send(8'hF0); send(8'h1C);

        // Pause with a key held: single E1 event, held key untouched.
        push(8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0);
        send(8'h1C);
        push(8'hE1, 1'b0, 1'b0, 8'h1C, 1'b0);
        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        push(8'h1C, 1'b0, 1'b1, 8'h00, 1'b0);
        send(8'hF0); send(8'h1C);

        // Stalled extended prefix times out.
        send(8'hE0);
        n = 0;
        for (int i = 1; i <= 2 * TO; i++) begin
            @(negedge clk);
            n = i;
            if (seq_err) break;
        end
        check("timeout_latency", 32'(n), 32'(TO));
        @(negedge clk);
        check("seq_err_width", 32'(seq_err), 32'd0);
        push(8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0);
        send(8'h1C);
        push(8'h1C, 1'b0, 1'b1, 8'h00, 1'b0);
        send(8'hF0); send(8'h1C);

        // Byte landing on the expiry cycle is processed, no timeout.
        send(8'hE0);
        repeat (TO - 2) @(negedge clk);
        push(8'h75, 1'b1, 1'b0, 8'h75, 1'b1);
        send(8'h75);
        push(8'h75, 1'b1, 1'b1, 8'h00, 1'b0);
        send(8'hE0); send(8'hF0); send(8'h75);

        // Reset in the middle of a break sequence.
        push(8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0);
        send(8'h1C);
        send(8'hF0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_key_code", 32'(key_code), 32'd0);
        check("mid_rst_held_code", 32'(held_code), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push(8'h1C, 1'b0, 1'b0, 8'h1C, 1'b0);
        send(8'h1C);

        // Bytes that must never produce an event.
        send(8'hAA); send(8'hFA);
        send(8'hE0); send(8'h12);
        send(8'hE0); send(8'hF0); send(8'h59);
        push(8'h1C, 1'b0, 1'b1, 8'h00, 1'b0);
        send(8'hF0); send(8'h1C);

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("seq_err_count", 32'(seq_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_scan_parser.md
Name: ps2_scan_parser

Overview:
- Sits between the PS/2 byte receiver and the key decoder.
- Consumes raw scan-code set 2 bytes, strips the E0 (extended), F0 (break) and E1 (pause) prefixes, and emits one clean press/release event per key.
- Provides a held "current key" byte so the decoder sees a stable code while a key is down.
- Suppresses typematic repeats and re-synchronises on stalled multi-byte sequences.

Parameters:
- TIMEOUT_CYCLES, 2500000, max clk cycles between bytes of one sequence (50 ms at 50 MHz) before the partial sequence is discarded.
- SUPPRESS_REPEAT, 1, when 1, repeated make codes of the currently held key are dropped.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx_done_tick  input  1  one-cycle strobe: din valid
- din  input  8  received byte from PS/2 receiver
- key_valid  output  1  one-cycle strobe: new event on key_code/extended/released
- key_code  output  8  scan code of last event (prefixes stripped); E1 for pause
- extended  output  1  event carried E0 prefix
- released  output  1  event was a break (F0)
- held_code  output  8  code of key currently held, 00 when none
- held_ext  output  1  extended flag of held key
- seq_err  output  1  one-cycle strobe: sequence aborted by timeout

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-high. While reset is high, all state is cleared.
- Reset values:
  - FSM = IDLE; timeout counter = 0; skip counter = 0.
  - Outputs: key_valid=0, key_code=00, extended=0, released=0, held_code=00, held_ext=0, seq_err=0.
- Bytes are only sampled on cycles with rx_done_tick=1; din is ignored otherwise.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), PAUSE (E1 seen, skipping).
- IDLE:
  - E0 -> EXT; F0 -> BRK; E1 -> PAUSE with skip count 7.
  - AA, FA, EE, FE, 00, FF are dropped with no event.
  - Any other byte -> make event, extended=0.
- EXT:
  - F0 -> EXT_BRK.
  - 12 or 59 (fake shifts) are dropped -> IDLE.
  - Any other byte -> make event, extended=1 -> IDLE.
- BRK: any byte -> break event, extended=0 -> IDLE.
- EXT_BRK: 12 or 59 are dropped -> IDLE; any other byte -> break event, extended=1 -> IDLE.
- PAUSE:
  - Each byte decrements the skip count.
  - On the 7th byte -> make event key_code=E1, extended=0 -> IDLE.
  - No break event is ever issued for pause.
- Event timing:
  - key_valid is asserted exactly one cycle after the rx_done_tick of the final byte.
  - key_code, extended and released update in that same cycle and hold until the next event.
- Held key:
  - A make event loads held_code/held_ext.
  - A break event whose code and extended flag match held_code/held_ext clears them to 00/0. A non-matching break leaves them unchanged.
  - Pause does not load held_code.
- Repeat suppression (SUPPRESS_REPEAT=1): a make whose code and extended flag equal held_code/held_ext produces no key_valid and no output change.
- Timeout:
  - The counter runs only in states other than IDLE, and restarts at 0 on every accepted byte.
  - When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE and seq_err pulses for one cycle. No event is emitted and held state is unchanged.
  - If rx_done_tick arrives on that same cycle, the byte wins: it is processed and there is no timeout.
- Back-to-back rx_done_tick on consecutive cycles is legal and must be handled.
- Reset asserted mid-sequence discards the partial sequence immediately. No key_valid or seq_err is issued during or after reset.

Test Plan:
- Byte 1C -> key_valid 1 cycle later, key_code=1C, extended=0, released=0, held_code=1C; then F0,1C -> key_valid, released=1, held_code=00.
- E0,75 then E0,F0,75 -> two events, both extended=1, released 0 then 1; held_ext goes 1 then 0.
- Make 1C three times (SUPPRESS_REPEAT=1) -> exactly one key_valid; with SUPPRESS_REPEAT=0 -> three key_valid pulses.
- Pause sequence E1,14,77,E1,F0,14,F0,77 -> single key_valid with key_code=E1; held_code unchanged; no spurious events from the embedded F0s.
- E0 followed by TIMEOUT_CYCLES idle cycles (TIMEOUT_CYCLES=100 in bench) -> seq_err pulse, FSM in IDLE; next byte 1C yields extended=0.
- Reset asserted after F0 mid-sequence, then byte 1C -> make event (released=0); AA, FA and E0,12 inputs -> no key_valid.
